// File: rtl/fetch_unit_pkg.sv
// Shared types for the BlimpV1 fetch stage: the {pc, inst} pair handed to decode.
package fetch_unit_pkg;

    localparam int unsigned P_INST_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Registered circular buffer of fetched {pc, inst} entries; flush empties it in one cycle.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter  int unsigned p_depth = 4,
    localparam int unsigned CW      = $clog2(p_depth + 1)
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         empty_o,
    output logic         full_o,
    output logic [CW-1:0] count_o
);
    localparam int unsigned AW = $clog2(p_depth);

    fetch_entry_t   mem_q [p_depth];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  cnt_q;
    logic           do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(p_depth));
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~flush_i & ~full_o;
    assign do_pop  = pop_i & ~flush_i & ~empty_o;

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// BlimpV1 fetch: credit-limited sequential PC+4 requests, in-order response buffering,
// {pc, inst} to decode over val/rdy, squash redirect with stale-response accounting.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned p_opaq_bits     = 8,
    parameter int unsigned p_max_in_flight = 4,
    parameter logic [31:0] p_rst_addr      = 32'h200
)(
    input  logic                   clk,
    input  logic                   rst,
    output logic                   mem_req_val,
    input  logic                   mem_req_rdy,
    output logic [31:0]            mem_req_addr,
    output logic [p_opaq_bits-1:0] mem_req_opaque,
    input  logic                   mem_resp_val,
    output logic                   mem_resp_rdy,
    input  logic [31:0]            mem_resp_data,
    input  logic [p_opaq_bits-1:0] mem_resp_opaque,
    input  logic                   squash_val,
    input  logic [31:0]            squash_target,
    output logic                   F_val,
    input  logic                   F_rdy,
    output logic [31:0]            F_pc,
    output logic [31:0]            F_inst
);
    localparam int unsigned CW = $clog2(p_max_in_flight + 1);

    logic [31:0]            req_pc_q, req_pc_d, resp_pc_q, resp_pc_d;
    logic [CW-1:0]          credits_q, credits_d, stale_q, stale_d, fifo_cnt;
    logic [p_opaq_bits-1:0] issue_cnt_q, exp_opaq_q;
    logic                   run_q;
    logic                   req_fire, resp_fire, drop_stale, push, f_fire;
    logic                   fifo_empty, fifo_full;
    fetch_entry_t           head;

    assign mem_req_val    = run_q & (credits_q < CW'(p_max_in_flight)) & ~squash_val;
    assign mem_req_addr   = req_pc_q;
    assign mem_req_opaque = issue_cnt_q;
    assign mem_resp_rdy   = 1'b1;

    assign req_fire   = mem_req_val & mem_req_rdy;
    assign resp_fire  = mem_resp_val;
    assign drop_stale = resp_fire & (stale_q != '0);
    assign push       = resp_fire & ~drop_stale & ~squash_val;

    assign F_val  = ~fifo_empty & ~squash_val;
    assign f_fire = F_val & F_rdy;
    assign F_pc   = head.pc;
    assign F_inst = head.inst;

    fetch_fifo #(.p_depth(p_max_in_flight)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i ('{pc: resp_pc_q, inst: mem_resp_data}),
        .pop_i       (f_fire),
        .flush_i     (squash_val),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (fifo_cnt)
    );

    always_comb begin
        req_pc_d  = req_pc_q;
        resp_pc_d = resp_pc_q;
        credits_d = credits_q;
        stale_d   = stale_q;
        if (squash_val) begin
            req_pc_d  = squash_target;
            resp_pc_d = squash_target;
            // Everything issued but not buffered is still owed by memory; a response
            // landing this cycle is one of those debts and is discarded right here.
            stale_d   = credits_q + CW'(req_fire) - fifo_cnt - CW'(resp_fire);
            credits_d = stale_d;
        end else begin
            if (req_fire)   req_pc_d  = req_pc_q + 32'(P_INST_BYTES);
            if (push)       resp_pc_d = resp_pc_q + 32'(P_INST_BYTES);
            if (drop_stale) stale_d   = stale_q - 1'b1;
            credits_d = credits_q + CW'(req_fire) - CW'(f_fire) - CW'(drop_stale);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            run_q       <= 1'b0;
            req_pc_q    <= p_rst_addr;
            resp_pc_q   <= p_rst_addr;
            credits_q   <= '0;
            stale_q     <= '0;
            issue_cnt_q <= '0;
            exp_opaq_q  <= '0;
        end else begin
            run_q     <= 1'b1;
            req_pc_q  <= req_pc_d;
            resp_pc_q <= resp_pc_d;
            credits_q <= credits_d;
            stale_q   <= stale_d;
            if (req_fire)  issue_cnt_q <= issue_cnt_q + 1'b1;
            if (resp_fire) exp_opaq_q  <= exp_opaq_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && resp_fire) begin
            assert (mem_resp_opaque == exp_opaq_q)
                else $error("fetch_unit: response opaque %0d, expected %0d", mem_resp_opaque, exp_opaq_q);
        end
        if (rst) begin
            assert (!(push && fifo_full))
                else $error("fetch_unit: push into full fetch buffer");
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: in-order memory model with delays, epoch-tagged requests,
// and a queue of wanted fetches that decode should see in order.
module tb_fetch_unit;
    localparam int unsigned OB  = 2;
    localparam int unsigned MIF = 4;
    localparam logic [31:0] RST_ADDR = 32'h200;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
    logic [31:0]   mem_req_addr, mem_resp_data;
    logic [OB-1:0] mem_req_opaque, mem_resp_opaque;
    logic          squash_val, F_val, F_rdy;
    logic [31:0]   squash_target, F_pc, F_inst;

    always #5 clk = ~clk;

    fetch_unit #(.p_opaq_bits(OB), .p_max_in_flight(MIF), .p_rst_addr(RST_ADDR)) dut (
        .clk(clk), .rst(rst),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
        .mem_req_addr(mem_req_addr), .mem_req_opaque(mem_req_opaque),
        .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
        .mem_resp_data(mem_resp_data), .mem_resp_opaque(mem_resp_opaque),
        .squash_val(squash_val), .squash_target(squash_target),
        .F_val(F_val), .F_rdy(F_rdy), .F_pc(F_pc), .F_inst(F_inst)
    );

    typedef struct {
        logic [31:0]   addr;
        int            due;
        int            ep;
        logic [OB-1:0] opq;
    } mreq_t;

    mreq_t       memq[$];     // requests memory still owes, oldest first
    logic [31:0] bufq[$];     // returned, still-wanted fetch addresses not yet taken by decode
    int          epoch, cyc, n_issued, errors, checks;
    logic [31:0] exp_req_pc;
    bit          running;
    int          dly_max, req_pct, frdy_pct, resp_pct;
    bit          resp_en;
    bit          obs_fval;
    logic [31:0] obs_fpc, obs_finst;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input bit sq, input logic [31:0] tgt);
        bit    rf, ff, pf;
        mreq_t h;
        @(negedge clk);
        squash_val    = sq;
        squash_target = tgt;
        mem_req_rdy   = ($urandom_range(99) < req_pct);
        F_rdy         = ($urandom_range(99) < frdy_pct);
        if (resp_en && memq.size() > 0 && memq[0].due <= cyc && $urandom_range(99) < resp_pct) begin
            mem_resp_val    = 1'b1;
            mem_resp_data   = inst_of(memq[0].addr);
            mem_resp_opaque = memq[0].opq;
        end else begin
            mem_resp_val    = 1'b0;
            mem_resp_data   = $urandom;
            mem_resp_opaque = '0;
        end
        #1;
        chk("req_val", 64'(mem_req_val), 64'(running && (memq.size() + bufq.size() < MIF) && !sq));
        chk("f_val", 64'(F_val), 64'(bufq.size() > 0 && !sq));
        rf = mem_req_val && mem_req_rdy;
        if (rf) begin
            chk("req_addr", 64'(mem_req_addr), 64'(exp_req_pc));
            chk("req_opaque", 64'(mem_req_opaque), 64'(n_issued % (1 << OB)));
        end
        if (F_val && bufq.size() > 0) begin
            chk("f_pc", 64'(F_pc), 64'(bufq[0]));
            chk("f_inst", 64'(F_inst), 64'(inst_of(bufq[0])));
        end
        obs_fval  = F_val;
        obs_fpc   = F_pc;
        obs_finst = F_inst;
        ff = F_val && F_rdy;
        pf = mem_resp_val;
        @(posedge clk);
        if (ff && !sq && bufq.size() > 0) void'(bufq.pop_front());
        if (pf) begin
            h = memq.pop_front();
            if (h.ep == epoch && !sq) bufq.push_back(h.addr);
        end
        if (rf) begin
            h.addr = mem_req_addr;
            h.due  = cyc + 1 + int'($urandom_range(dly_max));
            h.ep   = epoch;
            h.opq  = mem_req_opaque;
            memq.push_back(h);
            exp_req_pc += 32'd4;
            n_issued++;
        end
        if (sq) begin
            epoch++;
            bufq.delete();
            exp_req_pc = tgt;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; squash_val = 1'b0; mem_resp_val = 1'b0; F_rdy = 1'b0; mem_req_rdy = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
            chk("rst_req_val", 64'(mem_req_val), 64'd0);
            chk("rst_f_val", 64'(F_val), 64'd0);
        end
        memq.delete(); bufq.delete();
        epoch++; exp_req_pc = RST_ADDR; n_issued = 0; running = 1'b0;
        rst = 1'b1; #1;
        chk("rel_req_val", 64'(mem_req_val), 64'd0);
        @(posedge clk);
        running = 1'b1;
    endtask

    task automatic wait_first_f(input string tag, input logic [31:0] tgt);
        obs_fval = 1'b0;
        for (int i = 0; i < 40 && !obs_fval; i++) step(1'b0, 32'd0);
        chk(tag, 64'(obs_fval ? obs_fpc : 32'hDEAD_0000), 64'(tgt));
        chk({tag, "_inst"}, 64'(obs_fval ? obs_finst : 32'h0), 64'(inst_of(tgt)));
    endtask

    initial begin
        int          pick;
        logic [31:0] tgt;
        errors = 0; checks = 0; epoch = 0; cyc = 0; n_issued = 0; running = 1'b0;
        rst = 1'b0; mem_req_rdy = 1'b0; mem_resp_val = 1'b0; mem_resp_data = '0;
        mem_resp_opaque = '0; squash_val = 1'b0; squash_target = '0; F_rdy = 1'b0;
        exp_req_pc = RST_ADDR;

        // Zero-delay memory, decode always ready: straight sequential stream.
        dly_max = 0; req_pct = 100; frdy_pct = 100; resp_pct = 100; resp_en = 1'b1;
        do_reset();
        repeat (20) step(1'b0, 32'd0);

        // Decode stalled: credits cap the issue count.
        do_reset();
        frdy_pct = 0;
        repeat (10) step(1'b0, 32'd0);
        chk("stall_issued", 64'(n_issued), 64'(MIF));
        #1 chk("stall_req_val", 64'(mem_req_val), 64'd0);

        // Squash with three requests outstanding and nothing returned yet.
        do_reset();
        frdy_pct = 100; resp_en = 1'b0;
        repeat (3) step(1'b0, 32'd0);
        step(1'b1, 32'h400);
        resp_en = 1'b1;
        wait_first_f("sq3_first_pc", 32'h400);

        // Squash colliding with a returning response and buffered entries.
        do_reset();
        frdy_pct = 0;
        repeat (3) step(1'b0, 32'd0);
        frdy_pct = 100;
        step(1'b1, 32'h800);
        wait_first_f("sq_coll_first_pc", 32'h800);

        // PC wrap across 2^32.
        step(1'b1, 32'hFFFF_FFF8);
        repeat (12) step(1'b0, 32'd0);

        // Random delays, ready patterns and redirects.
        dly_max = 3; req_pct = 70; frdy_pct = 60; resp_pct = 70;
        for (int r = 0; r < 2; r++) begin
            do_reset();
            for (int i = 0; i < 1200; i++) begin
                pick = int'($urandom_range(99));
                tgt  = (pick % 3 == 0) ? 32'h400 : (pick % 3 == 1) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
                step(pick < 4, tgt);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
